harvard_data_responder: RTL

HARVARD_DATA_RESPONDER -- requirements
Module: harvard_data_responder

---
 rtl/harvard_data_responder_if.sv | 23 ++
 rtl/harvard_data_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/harvard_data_responder_if.sv
// CPU data-port bus plus the outbound TX stream and sticky error flag
// shared between the data responder and whatever drives it.
interface harvard_data_responder_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        err;

    modport master (
        output data_address, data_read, data_write, data_writedata, out_ready,
        input  data_readdata, out_valid, out_data, err
    );

    modport slave (
        input  data_address, data_read, data_write, data_writedata, out_ready,
        output data_readdata, out_valid, out_data, err
    );
endinterface

// File: rtl/harvard_data_responder.sv
// Data-side responder for a Harvard CPU: word RAM, free-running cycle counter,
// 8-deep TX FIFO and a status/error register, all behind zero-latency reads.
module harvard_data_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    harvard_data_responder_if.slave  bus
);
    localparam int          IDX_W   = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);
    localparam logic [29:0] CYC_WA  = MMIO_BASE[31:2];
    localparam logic [29:0] TX_WA   = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] ST_WA   = MMIO_BASE[31:2] + 30'd2;

    logic [31:0]      mem_q [RAM_WORDS];
    logic [31:0]      fifo_q [8];
    logic [31:0]      cycle_q, cycle_d;
    logic [2:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d, err_q, err_d;

    logic             ram_hit, cyc_hit, tx_hit, st_hit, mapped;
    logic [IDX_W-1:0] ram_idx;
    logic             wr_en, rd_en, err_set, ovf_set;
    logic             push_req, push_ok, pop, full, empty, valid;
    logic [31:0]      status, rdata;

    assign ram_hit = ({1'b0, bus.data_address} >= {1'b0, RAM_BASE}) &&
                     ({1'b0, bus.data_address} <  RAM_END);
    assign ram_idx = IDX_W'((bus.data_address - RAM_BASE) >> 2);
    assign cyc_hit = bus.data_address[31:2] == CYC_WA;
    assign tx_hit  = bus.data_address[31:2] == TX_WA;
    assign st_hit  = bus.data_address[31:2] == ST_WA;
    assign mapped  = ram_hit || cyc_hit || tx_hit || st_hit;

    // Simultaneous strobes are treated as a write; the read is suppressed.
    assign wr_en   = bus.data_write && !reset;
    assign rd_en   = bus.data_read && !bus.data_write && !reset;
    assign err_set = ((bus.data_read || bus.data_write) && !mapped) ||
                     (bus.data_read && bus.data_write);

    assign full     = count_q == 4'd8;
    assign empty    = count_q == 4'd0;
    assign valid    = !reset && !empty;
    assign push_req = wr_en && tx_hit;
    assign pop      = valid && bus.out_ready;
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign status = {22'd0, err_q, ovf_q, 2'd0, count_q, full, empty};

    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            if (ram_hit)     rdata = mem_q[ram_idx];
            else if (cyc_hit) rdata = cycle_q;
            else if (st_hit)  rdata = status;
        end
    end

    always_comb begin
        // A loaded value has already counted the cycle it was written in.
        cycle_d  = (wr_en && cyc_hit) ? bus.data_writedata + 32'd1 : cycle_q + 32'd1;
        wr_ptr_d = push_ok ? wr_ptr_q + 3'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 3'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_set || (ovf_q && !(wr_en && st_hit && bus.data_writedata[8]));
        err_d = err_set || (err_q && !(wr_en && st_hit && bus.data_writedata[9]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= 32'h0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Storage arrays carry no reset so RAM survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) mem_q[ram_idx] <= bus.data_writedata;
        if (push_ok) fifo_q[wr_ptr_q] <= bus.data_writedata;
    end

    assign bus.data_readdata = rdata;
    assign bus.out_valid     = valid;
    assign bus.out_data      = valid ? fifo_q[rd_ptr_q] : 32'h0;
    assign bus.err           = err_q;
endmodule
